serial_addsub: RTL and testbench
================================

# serial_addsub

Parametrised, bit-serial, two's-complement adder/subtractor for the Basys-3 arithmetic datapath. It generalises the board's 5-bit ripple adder to any `WIDTH`. The block time-shares a single full-adder cell over `WIDTH` clock cycles and adds a subtract mode and a signed-overflow flag. Operands are latched on a start/done handshake, so switch inputs may change while an operation runs; results are held stable for the LED/display stage downstream.

## Interface
Parameters:
- `WIDTH`, default 5: operand and result width in bits; legal range 2–32.

Ports:
- `clk`, in, 1: single system clock; all state updates on its rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `start`, in, 1: request an operation; sampled only in IDLE.
- `sub`, in, 1: 0 = A+B, 1 = A−B; latched with the operands.
- `a`, in, `WIDTH`: operand A; bit 0 is the LSB.
- `b`, in, `WIDTH`: operand B; bit 0 is the LSB.
- `busy`, out, 1: high while in SHIFT.
- `done`, out, 1: one-cycle pulse when a new result is valid.
- `sum`, out, `WIDTH`: result bits, held until the next completion.
- `cout`, out, 1: carry out of the MSB; for subtract, 1 = no borrow.
- `ovf`, out, 1: signed overflow = carry-into-MSB XOR carry-out-of-MSB.

## Operation
- States: IDLE, SHIFT, DONE. Encoding is free.
- Transitions:
  - IDLE → SHIFT on `start`=1.
  - SHIFT → DONE after `WIDTH` bit cycles.
  - DONE → IDLE unconditionally.
- Accept (IDLE and `start`=1):
  - latch `a` into shift register `ar`;
  - latch `b` into `br` if `sub`=0, or `~b` if `sub`=1;
  - carry register `c` ← `sub` (this forms the two's-complement +1);
  - bit counter ← 0.
- Each SHIFT cycle, with `s` = `ar[0]` ^ `br[0]` ^ `c`:
  - `ar` and `br` shift right by one;
  - `s` shifts into the MSB of result shift register `rr`;
  - `c` ← majority(`ar[0]`, `br[0]`, `c`);
  - counter increments.
- On the last bit cycle (counter = `WIDTH`−1), the pre-update `c` is captured as the carry-into-MSB.
- Entering DONE loads the outputs:
  - `sum` ← the final `rr` value, with all `WIDTH` bits in place and LSB at bit 0;
  - `cout` ← final `c`;
  - `ovf` ← captured carry-in XOR final `c`.
- Outputs `sum`, `cout` and `ovf` change only on entry to DONE or on reset. Internal shift registers are never visible on the outputs.
- Arithmetic:
  - `sum` = (A ± B) mod 2^`WIDTH`.
  - Add: {`cout`,`sum`} = A+B unsigned.
  - Subtract: `cout` = (A ≥ B) unsigned.
- Boundary conditions:
  - `start` in SHIFT or DONE is ignored and not queued.
  - Changes on `a`, `b` or `sub` after acceptance do not affect the running operation.
  - `start` held high continuously gives back-to-back operations, one every `WIDTH`+2 cycles.
  - `rst` during any state aborts the operation with no `done` pulse. Next cycle: state IDLE, all outputs at reset values.
- Reset values: state IDLE, `busy`=0, `done`=0, `sum`=0, `cout`=0, `ovf`=0, counter=0, `c`=0.

## Timing
- With `start` sampled high in IDLE at edge k:
  - edge k: → SHIFT; `busy`=1 from here.
  - edges k+1 … k+`WIDTH`: process bits 0 … `WIDTH`−1.
  - edge k+`WIDTH`: → DONE; `busy`=0, `done`=1, new `sum`/`cout`/`ovf` visible.
  - edge k+`WIDTH`+1: → IDLE, `done`=0.
  - earliest next accept: edge k+`WIDTH`+2.
- Latency from the accepting edge to `done`: `WIDTH` cycles. `done` stays high for exactly 1 cycle.
- `busy` and `done` are never high in the same cycle. Both are registered outputs with no combinational path from the inputs.
- The counter is ⌈log2(`WIDTH`)⌉+1 bits wide; it must not wrap before reaching `WIDTH`−1 for `WIDTH`=32.

## Test plan
- `WIDTH`=5, add 31+1 → after 5 cycles, `done` pulse; `sum`=0, `cout`=1, `ovf`=0.
- `WIDTH`=5, add 15+1 → `sum`=16, `cout`=0, `ovf`=1. Also add 5+9 → `sum`=14, `cout`=0, `ovf`=0.
- `WIDTH`=5, subtract 3−5 → `sum`=30, `cout`=0, `ovf`=0. Subtract 16−1 → `sum`=15, `cout`=1, `ovf`=1.
- `WIDTH`=5, pulse `start` again and change `a`/`b` mid-SHIFT → ignored. Exactly one `done`, with the original result; the previous `sum` is held until then.
- Assert `rst` for 1 cycle during SHIFT → no `done`; all outputs 0 next cycle. A fresh start then completes normally.
- `WIDTH`=8, `start` held high, 200 random add/sub vectors against a reference model → all results match, one `done` every 10 cycles.

Source files
------------

// File: rtl/serial_addsub_if.sv
// Operand/result bundle for serial_addsub.
// Handshake: start is sampled only while the block is idle; a sample with start=1 latches a, b and sub.
// done pulses for exactly one cycle when sum/cout/ovf hold a new result.
// busy is high while bits are being processed, and it is never high together with done.
interface serial_addsub_if #(
    parameter int WIDTH = 5
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic [1:0]       state_dbg;

    modport master (
        output start, sub, a, b,
        input  busy, done, sum, cout, ovf, state_dbg
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, sum, cout, ovf, state_dbg
    );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial two's-complement adder/subtractor: one full-adder cell is reused for WIDTH cycles.
// Results are registered on entry to DONE and are held until the next completion.
module serial_addsub #(
    parameter int WIDTH = 5
) (
    input logic           clk,
    input logic           rst,
    serial_addsub_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] ar;
    logic [WIDTH-1:0] br;
    logic [WIDTH-1:0] rr;
    logic [WIDTH-1:0] rr_next;
    logic [WIDTH-1:0] sum_q;
    logic [CW-1:0]    cnt;
    logic             c;
    logic             c_next;
    logic             s_bit;
    logic             last_bit;
    logic             cout_q;
    logic             ovf_q;

    always_comb begin
        state_next = state;
        s_bit      = ar[0] ^ br[0] ^ c;
        c_next     = (ar[0] & br[0]) | (ar[0] & c) | (br[0] & c);
        last_bit   = (cnt == CW'(WIDTH - 1));
        rr_next    = {s_bit, rr[WIDTH-1:1]};
        case (state)
            IDLE:    if (bus.start) state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ar     <= '0;
            br     <= '0;
            rr     <= '0;
            cnt    <= '0;
            c      <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        // Subtraction becomes A + ~B + 1, with the +1 entering as the initial carry.
                        ar  <= bus.a;
                        br  <= bus.sub ? ~bus.b : bus.b;
                        c   <= bus.sub;
                        cnt <= '0;
                    end
                end
                SHIFT: begin
                    ar  <= ar >> 1;
                    br  <= br >> 1;
                    rr  <= rr_next;
                    c   <= c_next;
                    cnt <= cnt + CW'(1);
                    if (last_bit) begin
                        // On the MSB cycle, c is the carry into the MSB and c_next is the carry out of it.
                        sum_q  <= rr_next;
                        cout_q <= c_next;
                        ovf_q  <= c ^ c_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = (state == SHIFT);
    assign bus.done      = (state == DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub at WIDTH=5 (directed cases) and WIDTH=8 (back-to-back random).
module tb_serial_addsub;
    logic clk;
    logic rst;

    serial_addsub_if #(.WIDTH(5)) i5 ();
    serial_addsub_if #(.WIDTH(8)) i8 ();

    serial_addsub #(.WIDTH(5)) u5 (.clk(clk), .rst(rst), .bus(i5));
    serial_addsub #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .bus(i8));

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    bit mon_en = 1'b0;
    int cyc    = 0;

    logic [6:0] exp5_q[$];
    logic [9:0] exp8_q[$];
    logic [6:0] held5 = '0;
    logic [9:0] held8 = '0;
    int last_done8 = -1;
    int done_cnt8  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, expv, cyc);
        end
    endtask

    // reference model: {ovf, cout, sum[31:0]} from plain integer arithmetic
    function automatic logic [33:0] ref_model(input int w, input longint ua, input longint ub, input bit sub);
        longint m, r, sa, sb, sr, half;
        logic cy, ov;
        logic [31:0] s;
        m    = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        sa   = (ua >= half) ? ua - (longint'(1) << w) : ua;
        sb   = (ub >= half) ? ub - (longint'(1) << w) : ub;
        if (sub) begin
            r  = ua - ub;
            sr = sa - sb;
            cy = (ua >= ub);
        end else begin
            r  = ua + ub;
            sr = sa + sb;
            cy = (r > m);
        end
        s  = 32'(r & m);
        ov = (sr > half - 1) || (sr < -half);
        return {ov, cy, s};
    endfunction

    // monitors
    always @(negedge clk) begin
        if (mon_en) begin
            if (i5.done) begin
                chk("busy_done_excl5", {63'd0, i5.busy}, 64'd0);
                if (exp5_q.size() == 0) begin
                    chk("unexpected_done5", 64'd1, 64'd0);
                end else begin
                    chk("result5", {57'd0, i5.ovf, i5.cout, i5.sum}, {57'd0, exp5_q.pop_front()});
                end
                held5 = {i5.ovf, i5.cout, i5.sum};
            end else if (!rst) begin
                chk("hold5", {57'd0, i5.ovf, i5.cout, i5.sum}, {57'd0, held5});
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (i8.done) begin
                chk("busy_done_excl8", {63'd0, i8.busy}, 64'd0);
                if (exp8_q.size() == 0) begin
                    chk("unexpected_done8", 64'd1, 64'd0);
                end else begin
                    chk("result8", {54'd0, i8.ovf, i8.cout, i8.sum}, {54'd0, exp8_q.pop_front()});
                end
                if (last_done8 >= 0) chk("period8", 64'(cyc - last_done8), 64'd10);
                last_done8 = cyc;
                done_cnt8++;
                held8 = {i8.ovf, i8.cout, i8.sum};
            end else if (!rst) begin
                chk("hold8", {54'd0, i8.ovf, i8.cout, i8.sum}, {54'd0, held8});
            end
        end
    end

    // driver tasks
    task automatic op5(input logic [4:0] av, input logic [4:0] bv, input bit sv, input bit disturb);
        logic [33:0] r;
        int n;
        @(posedge clk); #1;
        i5.a = av; i5.b = bv; i5.sub = sv; i5.start = 1'b1;
        r = ref_model(5, longint'(av), longint'(bv), sv);
        exp5_q.push_back({r[33], r[32], r[4:0]});
        @(posedge clk); #1;
        i5.start = 1'b0;
        chk("busy_after_accept5", {63'd0, i5.busy}, 64'd1);
        n = 0;
        while (n < 20 && !i5.done) begin
            if (disturb && n == 1) begin
                i5.start = 1'b1;
                i5.a     = 5'($urandom_range(0, 31));
                i5.b     = 5'($urandom_range(0, 31));
                i5.sub   = ~sv;
            end else if (disturb && n == 2) begin
                i5.start = 1'b0;
                i5.a     = 5'($urandom_range(0, 31));
            end
            @(posedge clk); #1;
            n++;
        end
        chk("latency5", 64'(n), 64'd5);
        @(posedge clk); #1;
        chk("done_one_cycle5", {63'd0, i5.done}, 64'd0);
        if (disturb) repeat (12) @(posedge clk);
    endtask

    task automatic set_vec8();
        logic [33:0] r;
        i8.a   = 8'($urandom_range(0, 255));
        i8.b   = 8'($urandom_range(0, 255));
        i8.sub = 1'($urandom_range(0, 1));
        r = ref_model(8, longint'(i8.a), longint'(i8.b), i8.sub);
        exp8_q.push_back({r[33], r[32], r[7:0]});
    endtask

    task automatic b2b8();
        @(posedge clk); #1;
        set_vec8();
        i8.start = 1'b1;
        for (int i = 1; i < 200; i++) begin
            repeat (10) @(posedge clk);
            #1;
            set_vec8();
        end
        @(posedge clk); #1;
        i8.start = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        i5.start = 1'b0; i5.sub = 1'b0; i5.a = '0; i5.b = '0;
        i8.start = 1'b0; i8.sub = 1'b0; i8.a = '0; i8.b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset5", {56'd0, i5.busy, i5.done, i5.ovf, i5.cout, i5.sum}, 64'd0);
        chk("reset8", {53'd0, i8.busy, i8.done, i8.ovf, i8.cout, i8.sum}, 64'd0);
        rst    = 1'b0;
        mon_en = 1'b1;

        op5(5'd31, 5'd1, 1'b0, 1'b0);
        op5(5'd15, 5'd1, 1'b0, 1'b0);
        op5(5'd5,  5'd9, 1'b0, 1'b0);
        op5(5'd3,  5'd5, 1'b1, 1'b0);
        op5(5'd16, 5'd1, 1'b1, 1'b0);
        op5(5'd0,  5'd0, 1'b1, 1'b0);
        op5(5'd10, 5'd7, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++)
            op5(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'b0);

        // reset in the middle of an operation: nothing is expected from it
        @(posedge clk); #1;
        i5.a = 5'd7; i5.b = 5'd6; i5.sub = 1'b0; i5.start = 1'b1;
        @(posedge clk); #1;
        i5.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst   = 1'b0;
        held5 = '0;
        chk("abort_outputs5", {56'd0, i5.busy, i5.done, i5.ovf, i5.cout, i5.sum}, 64'd0);
        repeat (10) @(posedge clk);
        op5(5'd12, 5'd9, 1'b0, 1'b0);

        b2b8();

        for (int t = 0; t < 60 && (exp5_q.size() > 0 || exp8_q.size() > 0); t++) @(posedge clk);
        repeat (4) @(posedge clk);
        chk("drain5", 64'(exp5_q.size()), 64'd0);
        chk("drain8", 64'(exp8_q.size()), 64'd0);
        chk("done_count8", 64'(done_cnt8), 64'd200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
